pc_stack_unit: RTL and testbench
================================

// Module: pc_stack_unit
// PURPOSE
//  Parametrised program counter with built-in circular return stack and PCLATH register for the PIC16-style core.
//  Next generation of the fixed 13-bit PC/8-deep stack pair: width, depth and vectors are generic.
//  Adds stack depth reporting, sticky overflow/underflow flags and a selectable wrap/saturate mode.
//  Driven by the control decoder; pc_out feeds program memory, pclath_out feeds the register file.
// PARAMETERS
//  PC_WIDTH      13  program counter width; PCLATH width = PC_WIDTH-8 (PC_WIDTH >= 9)
//  JADDR_WIDTH   11  GOTO/CALL literal width (8 <= JADDR_WIDTH <= PC_WIDTH)
//  STACK_DEPTH    8  number of return stack entries (power of two, >= 2)
//  RESET_VECTOR   0  PC value after reset
//  ISR_VECTOR     4  PC value loaded on interrupt entry
//  STACK_WRAP     1  1: circular, push on full overwrites oldest; 0: saturating, push on full dropped
// PORTS
//  clk              in   1              rising-edge clock
//  rst              in   1              synchronous, active-high reset
//  pc_incr_en       in   1              pc <= pc+1
//  pc_j_addr        in   JADDR_WIDTH    GOTO/CALL target literal
//  pc_j_en          in   1              jump (GOTO)
//  pc_j_and_push_en in   1              jump and push current pc (CALL)
//  pc_j_by_pop_en   in   1              pc <= top of stack, pop (RETURN/RETLW/RETFIE)
//  pc_j_to_isr      in   1              pc <= ISR_VECTOR, push current pc
//  pc_out           out  PC_WIDTH       current program counter
//  pclath_wr_en     in   1              write PCLATH register
//  pclath_in        in   PC_WIDTH-8     PCLATH write data
//  pclath_out       out  PC_WIDTH-8     PCLATH register contents
//  pcl_wr_en        in   1              computed jump: pc <= {pclath, pcl_in}
//  pcl_in           in   8              PCL write data
//  stk_flag_clr     in   1              clear stk_ovf and stk_unf
//  stk_count        out  clog2(DEPTH)+1 valid entries on stack, 0..STACK_DEPTH
//  stk_ovf          out  1              sticky: push attempted while full
//  stk_unf          out  1              sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset: pc=RESET_VECTOR, pclath=0, stk_count=0, write pointer=0, stk_ovf=stk_unf=0; stack RAM contents not cleared.
//  - All state updates on rising clk edge; pc_out is registered; top-of-stack read is combinational.
//  - Priority per cycle: pc_j_to_isr > (pc_j_en | pc_j_and_push_en) > pc_j_by_pop_en > default group.
//  - Jump target: {pclath[PC_WIDTH-9 : JADDR_WIDTH-8], pc_j_addr}; if JADDR_WIDTH==PC_WIDTH, pc_j_addr alone.
//  - Default group (no jump/pop/isr): pclath_wr_en updates pclath; pcl_wr_en sets pc={old pclath,pcl_in},
//    overriding pc_incr_en; else pc_incr_en sets pc=pc+1, wrapping all-ones -> 0.
//  - pclath only changes in default group; a pclath write coincident with any jump/pop/isr is discarded.
//  - Push (isr or j_and_push) stores current pc_out (already points past the CALL) at wptr; wptr++ mod DEPTH.
//  - Push when stk_count<DEPTH: count++. Push when full: stk_ovf<=1; WRAP=1 write and advance, count stays DEPTH;
//    WRAP=0 no write, wptr/count unchanged. The jump itself always happens.
//  - Pop: pc <= entry[wptr-1]; wptr--, count-- if count>0. Pop when empty: stk_unf<=1;
//    WRAP=1 pc<=entry[wptr-1], wptr-- (circular, count stays 0); WRAP=0 pc<=RESET_VECTOR, wptr unchanged.
//  - Push and pop same cycle: push wins (priority), pop ignored, no flag set by the ignored pop.
//  - stk_flag_clr clears flags; a new ovf/unf event in the same cycle wins (flag set).
//  - rst overrides everything, including mid-sequence push/pop; a stack emptied by reset reads stale data.
// TESTING
//  - Reset, 3x pc_incr_en -> pc_out 0,1,2,3; pclath_wr_en 5'h1A then pcl_wr_en 8'h40 -> pc 13'h1A40.
//  - pclath=5'h18, pc_j_and_push_en addr 11'h123 at pc=13'h0050 -> pc 13'h1923, count 1; pop -> pc 13'h0050, count 0.
//  - pc_j_to_isr at pc=13'h0200 -> pc 13'h0004, count+1; pop -> 13'h0200.
//  - WRAP=1: 9 CALLs pushing 1..9, then 8 pops -> 9,8,...,2; stk_ovf=1; 9th pop -> 9, stk_unf=1.
//  - WRAP=0: 9 CALLs -> count 8, ovf=1, 9th jump taken; 9 pops -> 8..1, then pc=RESET_VECTOR, unf=1.
//  - pc_j_en with pclath_wr_en and pc_incr_en same cycle -> jump target only, pclath unchanged; stk_flag_clr -> flags 0.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//   Program counter with PCLATH register and a circular return stack for a
//   PIC16-style core. Width, stack depth and vectors are parameters. The
//   stack reports its fill level and has sticky overflow and underflow flags.
//   STACK_WRAP selects what happens at the limits: circular operation, or
//   saturating operation where extra pushes are dropped.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   pc_incr_en          pc <= pc + 1
//   pc_j_addr/pc_j_en   GOTO to {pclath upper bits, literal}
//   pc_j_and_push_en    CALL: jump and push the current pc
//   pc_j_by_pop_en      RETURN: pc <= top of stack, then pop
//   pc_j_to_isr         interrupt entry: pc <= ISR_VECTOR, push the current pc
//   pc_out              registered program counter
//   pclath_wr_en/_in    PCLATH write; pclath_out holds the register contents
//   pcl_wr_en/pcl_in    computed jump: pc <= {pclath, pcl_in}
//   stk_flag_clr        clears stk_ovf and stk_unf
//   stk_count           number of valid stack entries, 0..STACK_DEPTH
//   stk_ovf, stk_unf    sticky flags: push while full, pop while empty
//
// Per-cycle priority:
//   interrupt entry > GOTO/CALL > RETURN > default group (pclath/pcl/incr)

module pc_stack_unit #(
    parameter int PC_WIDTH     = 13,
    parameter int JADDR_WIDTH  = 11,
    parameter int STACK_DEPTH  = 8,
    parameter int RESET_VECTOR = 0,
    parameter int ISR_VECTOR   = 4,
    parameter int STACK_WRAP   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pc_incr_en,
    input  logic [JADDR_WIDTH-1:0]         pc_j_addr,
    input  logic                           pc_j_en,
    input  logic                           pc_j_and_push_en,
    input  logic                           pc_j_by_pop_en,
    input  logic                           pc_j_to_isr,
    output logic [PC_WIDTH-1:0]            pc_out,
    input  logic                           pclath_wr_en,
    input  logic [PC_WIDTH-9:0]            pclath_in,
    output logic [PC_WIDTH-9:0]            pclath_out,
    input  logic                           pcl_wr_en,
    input  logic [7:0]                     pcl_in,
    input  logic                           stk_flag_clr,
    output logic [$clog2(STACK_DEPTH):0]   stk_count,
    output logic                           stk_ovf,
    output logic                           stk_unf
);

    localparam int PTR_W    = $clog2(STACK_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int PCLATH_W = PC_WIDTH - 8;

    localparam logic [PC_WIDTH-1:0] RST_PC   = PC_WIDTH'(RESET_VECTOR);
    localparam logic [PC_WIDTH-1:0] ISR_PC   = PC_WIDTH'(ISR_VECTOR);
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PCLATH_W-1:0] pclath_q, pclath_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    // The stack RAM is not reset. After a reset, a circular pop reads
    // whatever stale data the RAM still holds.
    logic [PC_WIDTH-1:0] stk_mem_q [STACK_DEPTH];
    logic                mem_we;

    logic [PC_WIDTH-1:0] j_target;
    logic [PTR_W-1:0]    wptr_dec;
    logic [PC_WIDTH-1:0] tos;
    logic                do_push;

    // GOTO/CALL literal is paged by the upper PCLATH bits it does not cover.
    generate
        if (JADDR_WIDTH == PC_WIDTH) begin : g_full_jaddr
            assign j_target = pc_j_addr;
        end else begin : g_paged_jaddr
            assign j_target = {pclath_q[PCLATH_W-1:JADDR_WIDTH-8], pc_j_addr};
        end
    endgenerate

    // The top of the stack is the entry just below the write pointer.
    assign wptr_dec = wptr_q - PTR_W'(1);
    assign tos      = stk_mem_q[wptr_dec];

    always_comb begin
        pc_d     = pc_q;
        pclath_d = pclath_q;
        wptr_d   = wptr_q;
        cnt_d    = cnt_q;
        // A clear takes effect unless a new event sets the flag again below.
        ovf_d    = ovf_q & ~stk_flag_clr;
        unf_d    = unf_q & ~stk_flag_clr;
        mem_we   = 1'b0;
        do_push  = 1'b0;

        if (pc_j_to_isr) begin
            pc_d    = ISR_PC;
            do_push = 1'b1;
        end else if (pc_j_en || pc_j_and_push_en) begin
            pc_d    = j_target;
            do_push = pc_j_and_push_en;
        end else if (pc_j_by_pop_en) begin
            if (cnt_q != '0) begin
                pc_d   = tos;
                wptr_d = wptr_dec;
                cnt_d  = cnt_q - CNT_W'(1);
            end else begin
                unf_d = 1'b1;
                if (STACK_WRAP != 0) begin
                    pc_d   = tos;
                    wptr_d = wptr_dec;
                end else begin
                    pc_d = RST_PC;
                end
            end
        end else begin
            if (pclath_wr_en) begin
                pclath_d = pclath_in;
            end
            // The computed jump uses the PCLATH value from before this cycle's write.
            if (pcl_wr_en) begin
                pc_d = {pclath_q, pcl_in};
            end else if (pc_incr_en) begin
                pc_d = pc_q + PC_WIDTH'(1);
            end
        end

        // A push saves pc_q, which already points past the CALL.
        if (do_push) begin
            if (cnt_q != FULL_CNT) begin
                mem_we = 1'b1;
                wptr_d = wptr_q + PTR_W'(1);
                cnt_d  = cnt_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
                if (STACK_WRAP != 0) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RST_PC;
            pclath_q <= '0;
            wptr_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pclath_q <= pclath_d;
            wptr_q   <= wptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            stk_mem_q[wptr_q] <= pc_q;
        end
    end

    assign pc_out     = pc_q;
    assign pclath_out = pclath_q;
    assign stk_count  = cnt_q;
    assign stk_ovf    = ovf_q;
    assign stk_unf    = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Testbench for pc_stack_unit. Two instances share the same inputs:
// index 0 saturates at the stack limits (STACK_WRAP=0) and index 1 wraps
// (STACK_WRAP=1). A behavioural model of each instance runs in lockstep.

module tb_pc_stack_unit;

    logic        clk;
    logic        rst;
    logic        pc_incr_en;
    logic [10:0] pc_j_addr;
    logic        pc_j_en;
    logic        pc_j_and_push_en;
    logic        pc_j_by_pop_en;
    logic        pc_j_to_isr;
    logic        pclath_wr_en;
    logic [4:0]  pclath_in;
    logic        pcl_wr_en;
    logic [7:0]  pcl_in;
    logic        stk_flag_clr;

    logic [12:0] pc_out_w [2];
    logic [4:0]  pclath_w [2];
    logic [3:0]  cnt_w [2];
    logic        ovf_w [2];
    logic        unf_w [2];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state, one set per instance.
    int m_pc [2];
    int m_pclath [2];
    int m_cnt [2];
    int m_ptr [2];
    int m_stk [2][8];
    bit m_ovf [2];
    bit m_unf [2];

    pc_stack_unit #(.STACK_WRAP(0)) dut_sat (
        .clk(clk), .rst(rst), .pc_incr_en(pc_incr_en), .pc_j_addr(pc_j_addr),
        .pc_j_en(pc_j_en), .pc_j_and_push_en(pc_j_and_push_en),
        .pc_j_by_pop_en(pc_j_by_pop_en), .pc_j_to_isr(pc_j_to_isr),
        .pc_out(pc_out_w[0]), .pclath_wr_en(pclath_wr_en), .pclath_in(pclath_in),
        .pclath_out(pclath_w[0]), .pcl_wr_en(pcl_wr_en), .pcl_in(pcl_in),
        .stk_flag_clr(stk_flag_clr), .stk_count(cnt_w[0]),
        .stk_ovf(ovf_w[0]), .stk_unf(unf_w[0])
    );

    pc_stack_unit #(.STACK_WRAP(1)) dut_wrap (
        .clk(clk), .rst(rst), .pc_incr_en(pc_incr_en), .pc_j_addr(pc_j_addr),
        .pc_j_en(pc_j_en), .pc_j_and_push_en(pc_j_and_push_en),
        .pc_j_by_pop_en(pc_j_by_pop_en), .pc_j_to_isr(pc_j_to_isr),
        .pc_out(pc_out_w[1]), .pclath_wr_en(pclath_wr_en), .pclath_in(pclath_in),
        .pclath_out(pclath_w[1]), .pcl_wr_en(pcl_wr_en), .pcl_in(pcl_in),
        .stk_flag_clr(stk_flag_clr), .stk_count(cnt_w[1]),
        .stk_ovf(ovf_w[1]), .stk_unf(unf_w[1])
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    task automatic model_push(input int w, input int value);
        if (m_cnt[w] < 8) begin
            m_stk[w][m_ptr[w]] = value;
            m_ptr[w] = (m_ptr[w] + 1) % 8;
            m_cnt[w] = m_cnt[w] + 1;
        end else begin
            m_ovf[w] = 1'b1;
            if (w == 1) begin
                m_stk[w][m_ptr[w]] = value;
                m_ptr[w] = (m_ptr[w] + 1) % 8;
            end
        end
    endtask

    task automatic model_step(input int w);
        int old_pc;
        old_pc = m_pc[w];
        if (rst) begin
            m_pc[w] = 0; m_pclath[w] = 0; m_cnt[w] = 0; m_ptr[w] = 0;
            m_ovf[w] = 1'b0; m_unf[w] = 1'b0;
            return;
        end
        if (stk_flag_clr) begin
            m_ovf[w] = 1'b0;
            m_unf[w] = 1'b0;
        end
        if (pc_j_to_isr) begin
            model_push(w, old_pc);
            m_pc[w] = 4;
        end else if (pc_j_en || pc_j_and_push_en) begin
            if (pc_j_and_push_en) model_push(w, old_pc);
            m_pc[w] = (m_pclath[w] / 8) * 2048 + int'(pc_j_addr);
        end else if (pc_j_by_pop_en) begin
            if (m_cnt[w] > 0) begin
                m_ptr[w] = (m_ptr[w] + 7) % 8;
                m_pc[w] = m_stk[w][m_ptr[w]];
                m_cnt[w] = m_cnt[w] - 1;
            end else begin
                m_unf[w] = 1'b1;
                if (w == 1) begin
                    m_ptr[w] = (m_ptr[w] + 7) % 8;
                    m_pc[w] = m_stk[w][m_ptr[w]];
                end else begin
                    m_pc[w] = 0;
                end
            end
        end else begin
            if (pcl_wr_en) m_pc[w] = m_pclath[w] * 256 + int'(pcl_in);
            else if (pc_incr_en) m_pc[w] = (old_pc + 1) % 8192;
            if (pclath_wr_en) m_pclath[w] = int'(pclath_in);
        end
    endtask

    // Driver tasks
    task automatic set_idle();
        rst = 1'b0; pc_incr_en = 1'b0; pc_j_addr = '0; pc_j_en = 1'b0;
        pc_j_and_push_en = 1'b0; pc_j_by_pop_en = 1'b0; pc_j_to_isr = 1'b0;
        pclath_wr_en = 1'b0; pclath_in = '0; pcl_wr_en = 1'b0; pcl_in = '0;
        stk_flag_clr = 1'b0;
    endtask

    // Applies the current inputs for one edge, then returns 1 time unit later.
    task automatic tick();
        @(posedge clk);
        for (int w = 0; w < 2; w++) model_step(w);
        #1;
        set_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick();
        rst = 1'b1; tick();
    endtask

    task automatic write_pclath(input logic [4:0] v);
        pclath_wr_en = 1'b1; pclath_in = v; tick();
    endtask

    task automatic write_pcl(input logic [7:0] v);
        pcl_wr_en = 1'b1; pcl_in = v; tick();
    endtask

    // Tests
    task automatic test_reset();
        do_reset();
        for (int w = 0; w < 2; w++) begin
            n_checks++; if (pc_out_w[w] !== 13'h0) begin n_errors++; $display("FAIL reset_pc[%0d]: got %h want 0", w, pc_out_w[w]); end
            n_checks++; if (pclath_w[w] !== 5'h0) begin n_errors++; $display("FAIL reset_pclath[%0d]: got %h want 0", w, pclath_w[w]); end
            n_checks++; if (cnt_w[w] !== 4'd0) begin n_errors++; $display("FAIL reset_count[%0d]: got %0d want 0", w, cnt_w[w]); end
            n_checks++; if (ovf_w[w] !== 1'b0 || unf_w[w] !== 1'b0) begin n_errors++; $display("FAIL reset_flags[%0d]: got ovf=%b unf=%b want 0 0", w, ovf_w[w], unf_w[w]); end
        end
    endtask

    task automatic test_incr_and_pcl();
        for (int k = 1; k <= 3; k++) begin
            pc_incr_en = 1'b1; tick();
            n_checks++; if (pc_out_w[1] !== 13'(k)) begin n_errors++; $display("FAIL incr_pc: got %h want %h", pc_out_w[1], 13'(k)); end
        end
        write_pclath(5'h1A);
        write_pcl(8'h40);
        n_checks++; if (pc_out_w[0] !== 13'h1A40) begin n_errors++; $display("FAIL pcl_jump_pc: got %h want 1a40", pc_out_w[0]); end
        n_checks++; if (pclath_w[0] !== 5'h1A) begin n_errors++; $display("FAIL pclath_write: got %h want 1a", pclath_w[0]); end
    endtask

    task automatic test_call_return();
        write_pclath(5'h00);
        write_pcl(8'h50);
        write_pclath(5'h18);
        pc_j_and_push_en = 1'b1; pc_j_addr = 11'h123; tick();
        n_checks++; if (pc_out_w[1] !== 13'h1923) begin n_errors++; $display("FAIL call_pc: got %h want 1923", pc_out_w[1]); end
        n_checks++; if (cnt_w[1] !== 4'd1) begin n_errors++; $display("FAIL call_count: got %0d want 1", cnt_w[1]); end
        pc_j_by_pop_en = 1'b1; tick();
        n_checks++; if (pc_out_w[1] !== 13'h0050) begin n_errors++; $display("FAIL return_pc: got %h want 0050", pc_out_w[1]); end
        n_checks++; if (cnt_w[1] !== 4'd0) begin n_errors++; $display("FAIL return_count: got %0d want 0", cnt_w[1]); end
    endtask

    task automatic test_isr();
        write_pclath(5'h02);
        write_pcl(8'h00);
        pc_j_to_isr = 1'b1; tick();
        n_checks++; if (pc_out_w[0] !== 13'h0004) begin n_errors++; $display("FAIL isr_pc: got %h want 0004", pc_out_w[0]); end
        n_checks++; if (cnt_w[0] !== 4'd1) begin n_errors++; $display("FAIL isr_count: got %0d want 1", cnt_w[0]); end
        pc_j_by_pop_en = 1'b1; tick();
        n_checks++; if (pc_out_w[0] !== 13'h0200) begin n_errors++; $display("FAIL retfie_pc: got %h want 0200", pc_out_w[0]); end
    endtask

    task automatic test_overflow_underflow();
        logic [10:0] last_addr;
        last_addr = '0;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            write_pcl(8'(k));
            last_addr = 11'($urandom_range(0, 2047));
            pc_j_and_push_en = 1'b1; pc_j_addr = last_addr; tick();
        end
        for (int w = 0; w < 2; w++) begin
            n_checks++; if (cnt_w[w] !== 4'd8) begin n_errors++; $display("FAIL full_count[%0d]: got %0d want 8", w, cnt_w[w]); end
            n_checks++; if (ovf_w[w] !== 1'b1) begin n_errors++; $display("FAIL ovf_set[%0d]: got %b want 1", w, ovf_w[w]); end
            n_checks++; if (pc_out_w[w] !== {2'b00, last_addr}) begin n_errors++; $display("FAIL full_call_pc[%0d]: got %h want %h", w, pc_out_w[w], {2'b00, last_addr}); end
        end
        for (int i = 1; i <= 8; i++) begin
            pc_j_by_pop_en = 1'b1; tick();
            n_checks++; if (pc_out_w[1] !== 13'(10 - i)) begin n_errors++; $display("FAIL wrap_pop_pc: got %h want %h", pc_out_w[1], 13'(10 - i)); end
            n_checks++; if (pc_out_w[0] !== 13'(9 - i)) begin n_errors++; $display("FAIL sat_pop_pc: got %h want %h", pc_out_w[0], 13'(9 - i)); end
            n_checks++; if (cnt_w[0] !== 4'(8 - i) || cnt_w[1] !== 4'(8 - i)) begin n_errors++; $display("FAIL pop_count: got %0d/%0d want %0d", cnt_w[0], cnt_w[1], 8 - i); end
        end
        n_checks++; if (unf_w[0] !== 1'b0 || unf_w[1] !== 1'b0) begin n_errors++; $display("FAIL unf_early: got %b/%b want 0", unf_w[0], unf_w[1]); end
        pc_j_by_pop_en = 1'b1; tick();
        n_checks++; if (pc_out_w[1] !== 13'd9) begin n_errors++; $display("FAIL wrap_empty_pop_pc: got %h want 0009", pc_out_w[1]); end
        n_checks++; if (pc_out_w[0] !== 13'd0) begin n_errors++; $display("FAIL sat_empty_pop_pc: got %h want 0000", pc_out_w[0]); end
        for (int w = 0; w < 2; w++) begin
            n_checks++; if (unf_w[w] !== 1'b1) begin n_errors++; $display("FAIL unf_set[%0d]: got %b want 1", w, unf_w[w]); end
            n_checks++; if (cnt_w[w] !== 4'd0) begin n_errors++; $display("FAIL empty_count[%0d]: got %0d want 0", w, cnt_w[w]); end
        end
    endtask

    task automatic test_flags();
        stk_flag_clr = 1'b1; tick();
        for (int w = 0; w < 2; w++) begin
            n_checks++; if (ovf_w[w] !== 1'b0 || unf_w[w] !== 1'b0) begin n_errors++; $display("FAIL flag_clear[%0d]: got ovf=%b unf=%b want 0 0", w, ovf_w[w], unf_w[w]); end
        end
        // Clear and a new underflow in the same cycle: the event wins.
        stk_flag_clr = 1'b1; pc_j_by_pop_en = 1'b1; tick();
        for (int w = 0; w < 2; w++) begin
            n_checks++; if (unf_w[w] !== 1'b1 || ovf_w[w] !== 1'b0) begin n_errors++; $display("FAIL clr_vs_unf[%0d]: got ovf=%b unf=%b want 0 1", w, ovf_w[w], unf_w[w]); end
        end
    endtask

    task automatic test_priority();
        do_reset();
        write_pclath(5'h1F);
        pc_j_en = 1'b1; pc_j_addr = 11'h2AB; pclath_wr_en = 1'b1; pclath_in = 5'h05; pc_incr_en = 1'b1; tick();
        n_checks++; if (pc_out_w[1] !== 13'h1AAB) begin n_errors++; $display("FAIL goto_prio_pc: got %h want 1aab", pc_out_w[1]); end
        n_checks++; if (pclath_w[1] !== 5'h1F) begin n_errors++; $display("FAIL goto_pclath_kept: got %h want 1f", pclath_w[1]); end
        // Push and pop together on an empty stack: push wins, no underflow.
        pc_j_and_push_en = 1'b1; pc_j_addr = 11'h011; pc_j_by_pop_en = 1'b1; tick();
        n_checks++; if (pc_out_w[0] !== 13'h1811 || cnt_w[0] !== 4'd1 || unf_w[0] !== 1'b0) begin n_errors++; $display("FAIL push_pop_same: got pc=%h cnt=%0d unf=%b want 1811 1 0", pc_out_w[0], cnt_w[0], unf_w[0]); end
        pc_j_to_isr = 1'b1; pc_j_en = 1'b1; pc_j_addr = 11'h7FF; tick();
        n_checks++; if (pc_out_w[1] !== 13'h0004 || cnt_w[1] !== 4'd2) begin n_errors++; $display("FAIL isr_prio: got pc=%h cnt=%0d want 0004 2", pc_out_w[1], cnt_w[1]); end
        pcl_wr_en = 1'b1; pcl_in = 8'h77; pc_incr_en = 1'b1; tick();
        n_checks++; if (pc_out_w[0] !== 13'h1F77) begin n_errors++; $display("FAIL pcl_over_incr: got %h want 1f77", pc_out_w[0]); end
        write_pcl(8'hFF);
        pc_incr_en = 1'b1; tick();
        n_checks++; if (pc_out_w[1] !== 13'h0000) begin n_errors++; $display("FAIL incr_wrap: got %h want 0000", pc_out_w[1]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst              = ($urandom_range(0, 59) == 0);
            pc_incr_en       = ($urandom_range(0, 1) == 0);
            pc_j_addr        = 11'($urandom_range(0, 2047));
            pc_j_en          = ($urandom_range(0, 7) == 0);
            pc_j_and_push_en = ($urandom_range(0, 4) == 0);
            pc_j_by_pop_en   = ($urandom_range(0, 3) == 0);
            pc_j_to_isr      = ($urandom_range(0, 15) == 0);
            pclath_wr_en     = ($urandom_range(0, 4) == 0);
            pclath_in        = 5'($urandom_range(0, 31));
            pcl_wr_en        = ($urandom_range(0, 5) == 0);
            pcl_in           = 8'($urandom_range(0, 255));
            stk_flag_clr     = ($urandom_range(0, 9) == 0);
            tick();
            for (int w = 0; w < 2; w++) begin
                n_checks++; if (pc_out_w[w] !== 13'(m_pc[w])) begin n_errors++; $display("FAIL rand_pc[%0d] cyc %0d: got %h want %h", w, c, pc_out_w[w], 13'(m_pc[w])); end
                n_checks++; if (pclath_w[w] !== 5'(m_pclath[w])) begin n_errors++; $display("FAIL rand_pclath[%0d] cyc %0d: got %h want %h", w, c, pclath_w[w], 5'(m_pclath[w])); end
                n_checks++; if (cnt_w[w] !== 4'(m_cnt[w])) begin n_errors++; $display("FAIL rand_count[%0d] cyc %0d: got %0d want %0d", w, c, cnt_w[w], m_cnt[w]); end
                n_checks++; if (ovf_w[w] !== m_ovf[w] || unf_w[w] !== m_unf[w]) begin n_errors++; $display("FAIL rand_flags[%0d] cyc %0d: got %b%b want %b%b", w, c, ovf_w[w], unf_w[w], m_ovf[w], m_unf[w]); end
            end
        end
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            m_pc[w] = 0; m_pclath[w] = 0; m_cnt[w] = 0; m_ptr[w] = 0;
            m_ovf[w] = 1'b0; m_unf[w] = 1'b0;
            for (int i = 0; i < 8; i++) m_stk[w][i] = 0;
        end
        set_idle();
        #2;
        test_reset();
        test_incr_and_pcl();
        test_call_return();
        test_isr();
        test_overflow_underflow();
        test_flags();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
